npu_cmd_ctrl: RTL and testbench
===============================

// Module: npu_cmd_ctrl
// PURPOSE
//  Memory-mapped command/sequencer that sits directly upstream of the NPU matrix engine. The CPU programs source and
//  destination word addresses over the clk_50 data bus, then writes START. The block then drives the NPU's
//  en/src1/src2/rd handshake, waits for the NPU completion ack, and reports status, cycle count, timeout and IRQ.
// PARAMETERS
//  MEM_WORDS   28       NPU shared-memory depth in words; a 3x3 operand/result block must fit below this.
//  MAT_WORDS   9        words per 3x3 matrix; operand/result span is addr..addr+MAT_WORDS-1.
//  CNT_W       16       width of the cycle counter and the timeout-limit register.
//  TMO_DEF     16'd256  reset value of the TIMEOUT register, in clk_50 cycles.
//  GAP_CYC     2        minimum npu_en-low cycles between two operations (lets the systolic array clear).
// PORTS
//  clk_50         in   1   bus/controller clock.
//  rst            in   1   reset: asynchronous, active-high.
//  sel            in   1   chip select; register access happens only when sel=1.
//  MEMRead        in   1   read strobe.
//  MEMWrite       in   1   write strobe (MEMWrite wins if both are set).
//  ADDR           in   32  byte address; ADDR[4:2] selects the register.
//  WD             in   32  write data.
//  RD             out  32  registered read data.
//  npu_en         out  1   NPU enable; held high for the whole operation.
//  npu_src1_addr  out  8   word address of matrix A.
//  npu_src2_addr  out  8   word address of matrix B.
//  npu_rd_addr    out  8   word address of result C.
//  npu_ack        in   1   NPU done pulse; may come from another clock domain.
//  irq            out  1   level interrupt = done & irq_en.
// BEHAVIOUR
//  Register map (word offset):
//   0 CTRL     bit0 START (write 1: pulse, reads 0); bit1 IRQ_EN (R/W); bit2 CLR (write 1: clears DONE/TMO/ERR).
//   1 SRC1, 2 SRC2, 3 DST  bits[7:0] R/W, upper bits read 0.
//   4 STATUS   bit0 BUSY, bit1 DONE, bit2 TMO, bit3 ERR (read-only).
//   5 CYCLES   cycles spent in RUN for the last operation (RO).
//   6 TIMEOUT  limit, CNT_W bits (R/W).
//   7          reserved: reads 0, writes ignored.
//  Reads: RD updates on the clock edge after sel&MEMRead and holds its value otherwise; never Z.
//  Reset values: RD=0, npu_en=0, all address outputs 0, irq=0, SRC/DST=0, TIMEOUT=TMO_DEF,
//   all STATUS bits 0, CYCLES=0, FSM in IDLE.
//  npu_ack path: 2-flop synchronizer, then rising-edge detect -> ack_evt (one clk_50 pulse).
//   Sync latency is 2-3 cycles.
//  FSM:
//   IDLE: START with SRC1, SRC2 and DST each <= MEM_WORDS-MAT_WORDS (i.e. <= 19) -> RUN.
//    Also on this transition: clear DONE/TMO/ERR and CYCLES; latch addresses onto the npu_* outputs.
//    START with any address out of range -> stay in IDLE, set ERR; npu_en is never raised.
//   RUN: npu_en=1, BUSY=1, CYCLES increments every cycle (saturates at all-ones).
//    ack_evt -> DONE_ST.
//    CYCLES == TIMEOUT (TIMEOUT != 0) -> ABORT.
//    If both occur in the same cycle, ack wins.
//   DONE_ST: npu_en=0, set DONE -> GAP.
//   ABORT: npu_en=0, set TMO -> GAP.
//   GAP: npu_en=0, BUSY=1 for GAP_CYC cycles -> IDLE.
//  While BUSY=1: START is ignored, and writes to SRC1/SRC2/DST are ignored.
//   npu_* address outputs stay stable from RUN entry to IDLE re-entry.
//  START and CLR written in the same cycle: CLR is applied first, then START is evaluated.
//  A late ack_evt arriving in GAP or IDLE is discarded.
//  TIMEOUT=0 disables the timeout.
//  Async rst mid-operation: npu_en drops immediately, FSM returns to IDLE, all registers go to reset values.
// TESTING
//  SRC1=0, SRC2=9, DST=18, START; ack pulses 12 cycles later.
//   -> npu_en high from the cycle after START until ack is seen; then DONE=1, BUSY=0 after GAP, CYCLES ~= 14-15.
//  IRQ_EN=1, then an operation completes -> irq=1. CLR -> irq=0 and DONE=0.
//  DST=20, START -> ERR=1, npu_en stays 0, BUSY=0.
//  TIMEOUT=5, START, no ack -> npu_en falls after 5 RUN cycles; TMO=1, CYCLES=5. A later ack is ignored.
//  Second START while BUSY, and a write SRC1=3 during RUN -> both ignored; npu_src1_addr unchanged.
//  Assert rst during RUN -> npu_en=0 at once, RD=0, TIMEOUT reads 256; next START still works.

Source files
------------

// File: rtl/npu_cmd_ctrl.sv
// Memory-mapped command sequencer for the NPU matrix engine: register file, ack synchronizer
// and run/timeout FSM driving the npu_en/src/rd handshake.
module npu_cmd_ctrl #(
  parameter int MEM_WORDS = 28,
  parameter int MAT_WORDS = 9,
  parameter int CNT_W     = 16,
  parameter int TMO_DEF   = 256,
  parameter int GAP_CYC   = 2
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        sel,
  input  logic        MEMRead,
  input  logic        MEMWrite,
  input  logic [31:0] ADDR,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        npu_en,
  output logic [7:0]  npu_src1_addr,
  output logic [7:0]  npu_src2_addr,
  output logic [7:0]  npu_rd_addr,
  input  logic        npu_ack,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, RUN, DONE_ST, ABORT, GAP} state_t;

  localparam logic [7:0] ADDR_MAX = 8'(MEM_WORDS - MAT_WORDS);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t state, next_state;

  logic [7:0]       src1, src2, dst;
  logic [CNT_W-1:0] timeout, cycles, cyc_inc;
  logic [7:0]       gap_cnt;
  logic             irq_en, done, tmo, err, busy;
  logic             ack_s1, ack_s2, ack_s3, ack_evt;
  logic [2:0]       reg_sel;
  logic             wr_en, rd_en, ctrl_wr, start_req, clr_req;
  logic             addr_ok, launch, reject, tmo_hit;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign unused_bits = ^{ADDR[31:5], ADDR[1:0], WD};

  assign reg_sel   = ADDR[4:2];
  assign wr_en     = sel & MEMWrite;
  assign rd_en     = sel & MEMRead & ~MEMWrite;
  assign ctrl_wr   = wr_en && (reg_sel == 3'd0);
  assign start_req = ctrl_wr & WD[0];
  assign clr_req   = ctrl_wr & WD[2];

  assign addr_ok = (src1 <= ADDR_MAX) && (src2 <= ADDR_MAX) && (dst <= ADDR_MAX);
  assign launch  = (state == IDLE) && start_req && addr_ok;
  assign reject  = (state == IDLE) && start_req && !addr_ok;

  // Timeout compares against the count this RUN cycle will leave behind, so TIMEOUT=N gives N RUN cycles.
  assign cyc_inc = (cycles == {CNT_W{1'b1}}) ? cycles : cycles + 1'b1;
  assign tmo_hit = (timeout != '0) && (cyc_inc == timeout);

  // npu_ack may be asynchronous: two flops, then a third for rising-edge detection.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
    end else begin
      ack_s1 <= npu_ack;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
    end
  end

  assign ack_evt = ack_s2 & ~ack_s3;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = RUN;
      RUN: begin
        if (ack_evt)      next_state = DONE_ST;
        else if (tmo_hit) next_state = ABORT;
      end
      DONE_ST: next_state = GAP;
      ABORT:   next_state = GAP;
      GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    npu_en = 1'b0;
    busy   = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      RUN:     npu_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      gap_cnt <= '0;
    end else begin
      if (launch)             cycles <= '0;
      else if (state == RUN)  cycles <= cyc_inc;
      if (state == GAP)       gap_cnt <= gap_cnt + 8'd1;
      else                    gap_cnt <= '0;
    end
  end

  // CLR is applied before a same-cycle START; a rejected START still leaves ERR set.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      tmo    <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      done <= (done & ~(clr_req | launch)) | (state == DONE_ST);
      tmo  <= (tmo  & ~(clr_req | launch)) | (state == ABORT);
      err  <= (err  & ~(clr_req | launch)) | reject;
      if (ctrl_wr) irq_en <= WD[1];
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      src1    <= '0;
      src2    <= '0;
      dst     <= '0;
      timeout <= CNT_W'(TMO_DEF);
    end else if (wr_en) begin
      case (reg_sel)
        3'd1:    if (!busy) src1 <= WD[7:0];
        3'd2:    if (!busy) src2 <= WD[7:0];
        3'd3:    if (!busy) dst  <= WD[7:0];
        3'd6:    timeout <= WD[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      npu_src1_addr <= '0;
      npu_src2_addr <= '0;
      npu_rd_addr   <= '0;
    end else if (launch) begin
      npu_src1_addr <= src1;
      npu_src2_addr <= src2;
      npu_rd_addr   <= dst;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      3'd0: rd_mux = {30'd0, irq_en, 1'b0};
      3'd1: rd_mux = {24'd0, src1};
      3'd2: rd_mux = {24'd0, src2};
      3'd3: rd_mux = {24'd0, dst};
      3'd4: rd_mux = {28'd0, err, tmo, done, busy};
      3'd5: rd_mux = 32'(cycles);
      3'd6: rd_mux = 32'(timeout);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)        RD <= '0;
    else if (rd_en) RD <= rd_mux;
  end

  assign irq = done & irq_en;

endmodule

// File: tb/tb_npu_cmd_ctrl.sv
// Directed self-checking bench for npu_cmd_ctrl: register table plus hand-timed operation sequences.
module tb_npu_cmd_ctrl;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        sel, MEMRead, MEMWrite, npu_ack;
  logic [31:0] ADDR, WD, RD;
  logic        npu_en, irq;
  logic [7:0]  npu_src1_addr, npu_src2_addr, npu_rd_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] R_CTRL = 3'd0, R_SRC1 = 3'd1, R_SRC2 = 3'd2, R_DST = 3'd3,
                         R_STAT = 3'd4, R_CYC = 3'd5, R_TMO = 3'd6, R_RSV = 3'd7;

  typedef struct {
    logic        is_write;
    logic [2:0]  reg_idx;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  npu_cmd_ctrl dut (
    .clk_50(clk_50), .rst(rst), .sel(sel), .MEMRead(MEMRead), .MEMWrite(MEMWrite),
    .ADDR(ADDR), .WD(WD), .RD(RD), .npu_en(npu_en), .npu_src1_addr(npu_src1_addr),
    .npu_src2_addr(npu_src2_addr), .npu_rd_addr(npu_rd_addr), .npu_ack(npu_ack), .irq(irq)
  );

  always #10 clk_50 = ~clk_50;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input logic [31:0] actual, input int lo, input int hi);
    checks++;
    if (actual < 32'(lo) || actual > 32'(hi)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Bus tasks start and end on a negedge; the access takes effect at the posedge in between.
  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
    sel = 1'b1; MEMWrite = 1'b1; MEMRead = 1'b0; ADDR = {27'd0, idx, 2'b00}; WD = data;
    @(negedge clk_50);
    sel = 1'b0; MEMWrite = 1'b0; WD = '0;
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
    sel = 1'b1; MEMRead = 1'b1; MEMWrite = 1'b0; ADDR = {27'd0, idx, 2'b00};
    @(negedge clk_50);
    sel = 1'b0; MEMRead = 1'b0;
    data = RD;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] d;
    if (v.is_write) bus_write(v.reg_idx, v.wd);
    else begin
      bus_read(v.reg_idx, d);
      checkOutput(v.name, d, v.exp_rd);
    end
  endtask

  task automatic pulse_ack();
    npu_ack = 1'b1;
    @(negedge clk_50);
    npu_ack = 1'b0;
  endtask

  task automatic wait_en_low(input string name, input int max_cyc);
    int n = 0;
    while (npu_en && n < max_cyc) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput(name, {31'd0, npu_en}, 32'd0);
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] r, input logic [31:0] d,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.is_write = w; v.reg_idx = r; v.wd = d; v.exp_rd = e; v.name = n;
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    int en_cnt;

    rst = 1'b1; sel = 0; MEMRead = 0; MEMWrite = 0; ADDR = '0; WD = '0; npu_ack = 0;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);

    checkOutput("reset_rd", RD, 32'd0);
    checkOutput("reset_en", {31'd0, npu_en}, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_addr", {8'd0, npu_src1_addr, npu_src2_addr, npu_rd_addr}, 32'd0);

    vecs.push_back(mk(0, R_TMO,  0, 32'd256, "rst_timeout"));
    vecs.push_back(mk(0, R_STAT, 0, 32'd0,   "rst_status"));
    vecs.push_back(mk(0, R_CYC,  0, 32'd0,   "rst_cycles"));
    vecs.push_back(mk(0, R_SRC1, 0, 32'd0,   "rst_src1"));
    vecs.push_back(mk(1, R_SRC1, 32'h5, 0, ""));
    vecs.push_back(mk(0, R_SRC1, 0, 32'h5,   "src1_rw"));
    vecs.push_back(mk(1, R_SRC1, 32'hFFFF_FF12, 0, ""));
    vecs.push_back(mk(0, R_SRC1, 0, 32'h12,  "src1_upper_zero"));
    vecs.push_back(mk(1, R_SRC2, 32'h9, 0, ""));
    vecs.push_back(mk(0, R_SRC2, 0, 32'h9,   "src2_rw"));
    vecs.push_back(mk(1, R_DST,  32'h12, 0, ""));
    vecs.push_back(mk(0, R_DST,  0, 32'h12,  "dst_rw"));
    vecs.push_back(mk(1, R_TMO,  32'hABCD_1234, 0, ""));
    vecs.push_back(mk(0, R_TMO,  0, 32'h1234, "timeout_rw"));
    vecs.push_back(mk(1, R_TMO,  32'd256, 0, ""));
    vecs.push_back(mk(1, R_CTRL, 32'h2, 0, ""));
    vecs.push_back(mk(0, R_CTRL, 0, 32'h2,   "ctrl_irq_en"));
    vecs.push_back(mk(1, R_CTRL, 32'h0, 0, ""));
    vecs.push_back(mk(0, R_CTRL, 0, 32'h0,   "ctrl_clear"));
    vecs.push_back(mk(1, R_RSV,  32'hFFFF_FFFF, 0, ""));
    vecs.push_back(mk(0, R_RSV,  0, 32'h0,   "reserved"));
    vecs.push_back(mk(1, R_SRC1, 32'h0, 0, ""));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    sel = 1'b1; MEMWrite = 1'b1; MEMRead = 1'b1; ADDR = {27'd0, R_SRC2, 2'b00}; WD = 32'h9;
    @(negedge clk_50);
    sel = 1'b0; MEMWrite = 1'b0; MEMRead = 1'b0;
    checkOutput("write_wins_rd_hold", RD, 32'h0);
    repeat (2) @(negedge clk_50);
    checkOutput("rd_hold", RD, 32'h0);

    // Normal operation: ack 12 cycles after START.
    bus_write(R_CTRL, 32'h3);
    checkOutput("run_en", {31'd0, npu_en}, 32'd1);
    checkOutput("run_addr", {8'd0, npu_src1_addr, npu_src2_addr, npu_rd_addr}, 32'h00_00_09_12);
    repeat (12) @(negedge clk_50);
    checkOutput("run_en_before_ack", {31'd0, npu_en}, 32'd1);
    pulse_ack();
    wait_en_low("ack_timeout", 10);
    repeat (5) @(negedge clk_50);
    bus_read(R_STAT, d);
    checkOutput("done_status", d, 32'h2);
    bus_read(R_CYC, d);
    checkRange("done_cycles", d, 14, 15);
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    bus_write(R_CTRL, 32'h6);
    checkOutput("irq_clr", {31'd0, irq}, 32'd0);
    bus_read(R_STAT, d);
    checkOutput("clr_status", d, 32'h0);

    // Out-of-range destination is rejected.
    bus_write(R_DST, 32'd20);
    bus_write(R_CTRL, 32'h1);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (npu_en) en_cnt++;
      @(negedge clk_50);
    end
    checkOutput("err_en_low", en_cnt, 32'd0);
    bus_read(R_STAT, d);
    checkOutput("err_status", d, 32'h8);
    bus_write(R_DST, 32'd18);
    bus_write(R_CTRL, 32'h4);

    // Timeout after 5 RUN cycles; a late ack is ignored.
    bus_write(R_TMO, 32'd5);
    bus_write(R_CTRL, 32'h1);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (npu_en) en_cnt++;
      @(negedge clk_50);
    end
    checkOutput("tmo_en_cycles", en_cnt, 32'd5);
    bus_read(R_STAT, d);
    checkOutput("tmo_status", d, 32'h4);
    bus_read(R_CYC, d);
    checkOutput("tmo_cycles", d, 32'd5);
    pulse_ack();
    repeat (6) @(negedge clk_50);
    bus_read(R_STAT, d);
    checkOutput("late_ack_ignored", d, 32'h4);

    // TIMEOUT=0 disables abort; writes and START during RUN are ignored.
    bus_write(R_TMO, 32'd0);
    bus_write(R_CTRL, 32'h1);
    bus_write(R_SRC1, 32'd3);
    bus_write(R_DST, 32'd5);
    bus_write(R_CTRL, 32'h1);
    bus_read(R_SRC1, d);
    checkOutput("busy_src1_reg", d, 32'd0);
    bus_read(R_STAT, d);
    checkOutput("busy_status", d, 32'h1);
    repeat (300) @(negedge clk_50);
    checkOutput("no_timeout_en", {31'd0, npu_en}, 32'd1);
    checkOutput("busy_addr_stable", {8'd0, npu_src1_addr, npu_src2_addr, npu_rd_addr}, 32'h00_00_09_12);
    pulse_ack();
    wait_en_low("ack2_timeout", 10);
    repeat (5) @(negedge clk_50);
    bus_read(R_STAT, d);
    checkOutput("busy_done_status", d, 32'h2);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (npu_en) en_cnt++;
      @(negedge clk_50);
    end
    checkOutput("no_second_op", en_cnt, 32'd0);

    // Asynchronous reset in the middle of RUN.
    bus_write(R_CTRL, 32'h1);
    checkOutput("rst_run_en", {31'd0, npu_en}, 32'd1);
    repeat (3) @(negedge clk_50);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_async_en", {31'd0, npu_en}, 32'd0);
    checkOutput("rst_async_rd", RD, 32'd0);
    @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
    bus_read(R_TMO, d);
    checkOutput("rst_timeout_256", d, 32'd256);
    bus_read(R_STAT, d);
    checkOutput("rst_status_clear", d, 32'h0);
    bus_write(R_CTRL, 32'h1);
    checkOutput("restart_en", {31'd0, npu_en}, 32'd1);
    repeat (4) @(negedge clk_50);
    pulse_ack();
    wait_en_low("ack3_timeout", 10);
    repeat (5) @(negedge clk_50);
    bus_read(R_STAT, d);
    checkOutput("restart_done", d, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
